prescaled_digit_counter: RTL and testbench
==========================================

PRESCALED_DIGIT_COUNTER -- requirements
Module: prescaled_digit_counter

Interface
REQ-001 SHALL have parameter CNT_W, default 24, prescaler counter width.
REQ-002 SHALL have parameter SHIFT, default 10, left shift applied to period; SHIFT+8 <= CNT_W.
REQ-003 SHALL have parameter NDIG, default 4, number of cascaded digits, legal range 1..8.
REQ-004 SHALL have parameter MODULUS, default 10, digit modulus, legal range 2..16.
REQ-005 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  count enable; low holds all state.
REQ-008 SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL have port clr  input  1  synchronous clear of prescaler and digits.
REQ-010 SHALL have port load  input  1  synchronous load of digits from load_val.
REQ-011 SHALL have port load_val  input  4*NDIG  digit load value; digit i in bits [4i+3:4i].
REQ-012 SHALL have port period  input  8  prescaler period selector.
REQ-013 SHALL have port digits  output  4*NDIG  current digit values; digit 0 least significant.
REQ-014 SHALL have port tick  output  1  one-cycle pulse per prescaler terminal count.
REQ-015 SHALL have port wrap  output  1  one-cycle pulse when whole digit chain wraps.
REQ-016 SHALL have port pre_cnt  output  CNT_W  current prescaler count.

Function
REQ-017 compare SHALL equal {period, SHIFT zeros} zero-extended to CNT_W.
REQ-018 With en=1, prescaler SHALL reset to 0 on a cycle where pre_cnt >= compare, else increment by 1.
REQ-019 Terminal condition SHALL use >=, so lowering period mid-count below pre_cnt terminates on the next enabled cycle (no 2^CNT_W overrun).
REQ-020 period=0 SHALL give a terminal count every enabled cycle.
REQ-021 tick SHALL be registered: high exactly the cycle after a terminal-count cycle, coincident with the updated digits.
REQ-022 On terminal count, digit 0 SHALL step; digit i (i>0) SHALL step only if all lower digits are at their terminal value.
REQ-023 Up terminal value SHALL be MODULUS-1, stepping to 0; down terminal value SHALL be 0, stepping to MODULUS-1.
REQ-024 wrap SHALL pulse (same cycle as tick) when all NDIG digits wrapped on that step, e.g. 9999->0000 up, 0000->9999 down.
REQ-025 up_dn change SHALL take effect on the next terminal count; prescaler unaffected.
REQ-026 en=0 SHALL hold prescaler and digits; tick and wrap SHALL be 0 the following cycle.
REQ-027 load=1 SHALL set digits from load_val and pre_cnt to 0; any nibble >= MODULUS SHALL load as 0; tick/wrap 0 next cycle.
REQ-028 clr=1 SHALL set pre_cnt and all digits to 0; tick/wrap 0 next cycle.
REQ-029 Priority SHALL be reset > clr > load > counting; load and clr act regardless of en.
REQ-030 Digit arithmetic SHALL never produce a value >= MODULUS on digits.

Reset
REQ-031 On reset=1 at a clock edge, pre_cnt, digits, tick and wrap SHALL all be 0 next cycle.
REQ-032 Reset asserted mid-count SHALL discard partial prescaler count; counting SHALL resume from 0 on the first cycle after reset deasserts with en=1.

Verification
REQ-033 Defaults, period=0, en=1, up: digits read 0001,0002,... on successive cycles, tick high every cycle; after 10000 cycles digits=0000 with wrap=1 for one cycle.
REQ-034 Defaults, period=1 (compare=1024): tick pulses every 1025 cycles; pre_cnt counts 0..1024.
REQ-035 pre_cnt=3000 with period=3, then period set to 1: terminal count next cycle, pre_cnt=0, tick next cycle.
REQ-036 load with load_val=0x00F9 (MODULUS=10): digits=0x0009; then down with period=0: 0008...0000, then 9999 with wrap=1.
REQ-037 Simultaneous clr=1, load=1, en=1: digits=0, pre_cnt=0, tick=0; en=0 for 50 cycles: digits and pre_cnt unchanged.
REQ-038 reset asserted at pre_cnt=500, digits=0042: next cycle all outputs 0; after release counting restarts from pre_cnt=0.

Source files
------------

// File: rtl/prescaled_digit_counter.sv
// Prescaled up/down counter: a programmable prescaler gates a cascade of
// modulo-MODULUS digits, with load, clear and chain-wrap indication.
module prescaled_digit_counter #(
  parameter int unsigned CNT_W   = 24,
  parameter int unsigned SHIFT   = 10,
  parameter int unsigned NDIG    = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                up_dn,
  input  logic                clr,
  input  logic                load,
  input  logic [4*NDIG-1:0]   load_val,
  input  logic [7:0]          period,
  output logic [4*NDIG-1:0]   digits,
  output logic                tick,
  output logic                wrap,
  output logic [CNT_W-1:0]    pre_cnt
);

  localparam int unsigned DW      = 4 * NDIG;
  localparam logic [3:0]  DIG_MAX = 4'(MODULUS - 1);
  localparam logic [4:0]  DIG_MOD = 5'(MODULUS);

  logic [CNT_W-1:0] r_pre_cnt;
  logic [DW-1:0]    r_digits;
  logic             r_tick;
  logic             r_wrap;

  logic [CNT_W-1:0] w_compare;
  logic             w_term;
  logic [DW-1:0]    w_digits_nxt;
  logic [DW-1:0]    w_load_digits;
  logic             w_wrap;

  // >= rather than == so a shrinking period never lets the count run away
  assign w_compare = CNT_W'(period) << SHIFT;
  assign w_term    = (r_pre_cnt >= w_compare);

  // Ripple-carry digit step and load-value sanitising
  always_comb begin : p_digit_next
    logic v_carry;
    logic v_at_term;
    v_carry       = 1'b1;
    v_at_term     = 1'b0;
    w_digits_nxt  = r_digits;
    w_load_digits = '0;
    for (int i = 0; i < int'(NDIG); i++) begin
      v_at_term = up_dn ? (r_digits[4*i +: 4] == DIG_MAX)
                        : (r_digits[4*i +: 4] == 4'd0);
      if (v_carry) begin
        if (v_at_term)
          w_digits_nxt[4*i +: 4] = up_dn ? 4'd0 : DIG_MAX;
        else
          w_digits_nxt[4*i +: 4] = up_dn ? (r_digits[4*i +: 4] + 4'd1)
                                         : (r_digits[4*i +: 4] - 4'd1);
      end
      v_carry = v_carry & v_at_term;
      w_load_digits[4*i +: 4] = ({1'b0, load_val[4*i +: 4]} >= DIG_MOD)
                                ? 4'd0 : load_val[4*i +: 4];
    end
    w_wrap = v_carry;
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_pre_cnt <= '0;
      r_digits  <= '0;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (load) begin
      r_pre_cnt <= '0;
      r_digits  <= w_load_digits;
      r_tick    <= 1'b0;
      r_wrap    <= 1'b0;
    end else if (en) begin
      r_pre_cnt <= w_term ? '0 : (r_pre_cnt + CNT_W'(1));
      if (w_term)
        r_digits <= w_digits_nxt;
      r_tick <= w_term;
      r_wrap <= w_term & w_wrap;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
    end
  end

  assign digits  = r_digits;
  assign tick    = r_tick;
  assign wrap    = r_wrap;
  assign pre_cnt = r_pre_cnt;

endmodule

// File: tb/tb_prescaled_digit_counter.sv
// Bench for prescaled_digit_counter (default parameters): a decimal-value
// reference model queues expected outputs each cycle for comparison.
module tb_prescaled_digit_counter;

  logic        clk = 1'b0;
  logic        reset, en, up_dn, clr, load;
  logic [15:0] load_val;
  logic [7:0]  period;
  logic [15:0] digits;
  logic        tick, wrap;
  logic [23:0] pre_cnt;

  prescaled_digit_counter #(
    .CNT_W(24), .SHIFT(10), .NDIG(4), .MODULUS(10)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .clr(clr),
    .load(load), .load_val(load_val), .period(period),
    .digits(digits), .tick(tick), .wrap(wrap), .pre_cnt(pre_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        t;
    logic        w;
    logic [23:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_pre    = 0;   // model prescaler
  int   m_val    = 0;   // model digit chain as a plain integer 0..9999
  int   tick_cnt = 0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v, scale;
    v = 0;
    scale = 1;
    for (int i = 0; i < 4; i++) begin
      if (int'(lv[4*i +: 4]) < 10) v += int'(lv[4*i +: 4]) * scale;
      scale *= 10;
    end
    return v;
  endfunction

  task automatic check1(input string tag, input logic [23:0] got, input logic [23:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, advance the model, push expectation, then compare.
  task automatic step(input logic rst, input logic e, input logic up, input logic cl,
                      input logic ld, input logic [15:0] lv, input logic [7:0] per);
    exp_t ex, got;
    bit   term;
    reset = rst; en = e; up_dn = up; clr = cl; load = ld; load_val = lv; period = per;
    ex.t = 1'b0;
    ex.w = 1'b0;
    if (rst || cl) begin
      m_pre = 0; m_val = 0;
    end else if (ld) begin
      m_pre = 0; m_val = from_load(lv);
    end else if (e) begin
      term = (m_pre >= (int'(per) << 10));
      m_pre = term ? 0 : m_pre + 1;
      if (term) begin
        ex.t = 1'b1;
        if (up) begin
          ex.w  = (m_val == 9999);
          m_val = (m_val + 1) % 10000;
        end else begin
          ex.w  = (m_val == 0);
          m_val = (m_val + 9999) % 10000;
        end
      end
    end
    ex.d = to_bcd(m_val);
    ex.p = 24'(m_pre);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    if (tick === 1'b1) tick_cnt++;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check1("digits",  24'(digits), 24'(got.d));
      check1("tick",    24'(tick),   24'(got.t));
      check1("wrap",    24'(wrap),   24'(got.w));
      check1("pre_cnt", pre_cnt,     got.p);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
    load_val = '0; period = '0;

    // reset state
    step(1, 0, 1, 0, 0, 16'h0, 8'd0);
    step(1, 1, 1, 0, 0, 16'h0, 8'd0);

    // period 0 counting up through a full chain wrap
    for (int i = 0; i < 10000; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd0);
    check1("wrap_after_10000_digits", 24'(digits), 24'h0);

    // period 1: tick every 1025 cycles
    step(0, 1, 1, 1, 0, 16'h0, 8'd1);
    tick_cnt = 0;
    for (int i = 0; i < 2100; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd1);
    check1("tick_count_2100", 24'(tick_cnt), 24'd2);

    // lowering period below the running count terminates next cycle
    step(0, 1, 1, 1, 0, 16'h0, 8'd3);
    for (int i = 0; i < 3000; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd3);
    check1("pre_at_3000", pre_cnt, 24'd3000);
    step(0, 1, 1, 0, 0, 16'h0, 8'd1);
    check1("period_drop_tick", 24'(tick), 24'd1);
    step(0, 1, 1, 0, 0, 16'h0, 8'd1);

    // load with an out-of-range nibble, then count down through wrap
    step(0, 1, 0, 0, 1, 16'h00F9, 8'd0);
    check1("load_sanitised", 24'(digits), 24'h0009);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 0, 16'h0, 8'd0);

    // direction change mid-stream and a nibble at modulus-1 boundary
    step(0, 1, 1, 0, 1, 16'h9899, 8'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 16'h0, 8'd0);

    // clr beats load; en low holds everything
    step(0, 1, 1, 1, 1, 16'h1234, 8'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd0);
    step(0, 1, 1, 0, 0, 16'h0, 8'd2);
    for (int i = 0; i < 50; i++) step(0, 0, 1, 0, 0, 16'h0, 8'd2);
    // load acts with en low
    step(0, 0, 1, 0, 1, 16'h0042, 8'd3);

    // reset mid-count, then restart from zero
    for (int i = 0; i < 500; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd3);
    check1("pre_before_reset", pre_cnt, 24'd500);
    step(1, 1, 1, 0, 0, 16'h0, 8'd3);
    step(0, 0, 1, 0, 0, 16'h0, 8'd3);
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 16'h0, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
